// File: rtl/main_sound_mailbox_if.sv
// Signal bundle between the 68k/sound-CPU decode logic and the sound-command mailbox.
// The master side drives strobes and data; the slave side (the mailbox) returns status.
interface main_sound_mailbox_if;
    logic       wr68k_stb;
    logic [7:0] wr68k_data;
    logic       rd68k_stb;
    logic [7:0] rd68k_data;
    logic       rsp_valid;
    logic       cmd_full;
    logic [1:0] ovf_flags;
    logic       ovf_clr;
    logic       snd_rd_stb;
    logic [7:0] snd_cmd_data;
    logic       snd_cmd_pend;
    logic       snd_wr_stb;
    logic [7:0] snd_wr_data;
    logic       sndnmi;

    modport master (
        output wr68k_stb, wr68k_data, rd68k_stb, ovf_clr,
        output snd_rd_stb, snd_wr_stb, snd_wr_data,
        input  rd68k_data, rsp_valid, cmd_full, ovf_flags,
        input  snd_cmd_data, snd_cmd_pend, sndnmi
    );

    modport slave (
        input  wr68k_stb, wr68k_data, rd68k_stb, ovf_clr,
        input  snd_rd_stb, snd_wr_stb, snd_wr_data,
        output rd68k_data, rsp_valid, cmd_full, ovf_flags,
        output snd_cmd_data, snd_cmd_pend, sndnmi
    );
endinterface

// File: rtl/main_sound_mailbox.sv
// 68k -> sound CPU command FIFO with one NMI pulse per queued command,
// plus a single-byte sound CPU -> 68k response latch with sticky overflow flags.
module main_sound_mailbox #(
    parameter int CMD_DEPTH = 4,
    parameter int NMI_WIDTH = 8,
    parameter int NMI_GAP   = 4
) (
    input  logic                 clock_15,
    input  logic                 rst,
    main_sound_mailbox_if.slave  bus
);
    localparam int PW   = $clog2(CMD_DEPTH);
    localparam int CW   = PW + 1;
    localparam int TMAX = (NMI_WIDTH > NMI_GAP) ? NMI_WIDTH : NMI_GAP;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT_ACK, S_GAP} state_t;

    logic [7:0]    r_fifo [CMD_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_cmd_data;
    logic [7:0]    r_rsp_data;
    logic          r_rsp_valid;
    logic [1:0]    r_ovf;
    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic          r_ack;
    logic          r_sndnmi;

    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic          w_cmd_ovf;
    logic          w_rsp_ovf;
    logic [CW-1:0] w_count_after_pop;
    logic [CW-1:0] w_count_next;
    logic [PW-1:0] w_rd_ptr_next;
    logic [7:0]    w_head_next;

    assign w_full            = (r_count == CW'(CMD_DEPTH));
    assign w_empty           = (r_count == '0);
    assign w_pop             = bus.snd_rd_stb && !w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_push            = bus.wr68k_stb && (!w_full || w_pop);
    assign w_cmd_ovf         = bus.wr68k_stb && w_full && !w_pop;
    assign w_rsp_ovf         = bus.snd_wr_stb && r_rsp_valid && !bus.rd68k_stb;
    assign w_count_after_pop = r_count - CW'(w_pop);
    assign w_count_next      = w_count_after_pop + CW'(w_push);
    assign w_rd_ptr_next     = r_rd_ptr + PW'(w_pop);

    // Registered head: if the only surviving entry is this cycle's push, bypass the array.
    always_comb begin
        w_head_next = r_cmd_data;
        if (w_count_next != '0) begin
            if (w_count_after_pop == '0)
                w_head_next = bus.wr68k_data;
            else
                w_head_next = r_fifo[w_rd_ptr_next];
        end
    end

    always_ff @(posedge clock_15) begin
        if (w_push)
            r_fifo[r_wr_ptr] <= bus.wr68k_data;
    end

    always_ff @(posedge clock_15 or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_cmd_data <= '0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + PW'(w_push);
            r_rd_ptr   <= w_rd_ptr_next;
            r_count    <= w_count_next;
            r_cmd_data <= w_head_next;
        end
    end

    always_ff @(posedge clock_15 or posedge rst) begin
        if (rst) begin
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_ovf       <= '0;
        end else begin
            if (bus.snd_wr_stb) begin
                r_rsp_data  <= bus.snd_wr_data;
                r_rsp_valid <= 1'b1;
            end else if (bus.rd68k_stb) begin
                r_rsp_valid <= 1'b0;
            end
            // A same-cycle overflow wins over the clear.
            r_ovf <= (bus.ovf_clr ? 2'b00 : r_ovf) | {w_rsp_ovf, w_cmd_ovf};
        end
    end

    always_ff @(posedge clock_15 or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_ack    <= 1'b0;
            r_sndnmi <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_state  <= S_PULSE;
                        r_timer  <= TW'(NMI_WIDTH - 1);
                        r_ack    <= 1'b0;
                        r_sndnmi <= 1'b1;
                    end
                end
                S_PULSE: begin
                    if (r_timer == '0) begin
                        r_sndnmi <= 1'b0;
                        if (r_ack || w_pop) begin
                            r_state <= S_GAP;
                            r_timer <= TW'(NMI_GAP - 1);
                        end else begin
                            r_state <= S_WAIT_ACK;
                        end
                    end else begin
                        r_timer <= r_timer - 1'b1;
                        if (w_pop)
                            r_ack <= 1'b1;
                    end
                end
                S_WAIT_ACK: begin
                    if (w_pop) begin
                        r_state <= S_GAP;
                        r_timer <= TW'(NMI_GAP - 1);
                    end
                end
                S_GAP: begin
                    if (r_timer == '0)
                        r_state <= S_IDLE;
                    else
                        r_timer <= r_timer - 1'b1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_sndnmi <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd68k_data   = r_rsp_data;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.cmd_full     = w_full;
    assign bus.ovf_flags    = r_ovf;
    assign bus.snd_cmd_data = r_cmd_data;
    assign bus.snd_cmd_pend = !w_empty;
    assign bus.sndnmi       = r_sndnmi;
endmodule

// File: tb/tb_main_sound_mailbox.sv
// Bench for main_sound_mailbox: command scoreboard queue, NMI pulse timing,
// a vector table for the response latch, and asynchronous reset mid-pulse.
module tb_main_sound_mailbox;
    localparam int DEPTH = 4;
    localparam int W     = 8;
    localparam int G     = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    main_sound_mailbox_if bus();

    main_sound_mailbox #(.CMD_DEPTH(DEPTH), .NMI_WIDTH(W), .NMI_GAP(G)) dut (
        .clock_15 (clk),
        .rst      (rst),
        .bus      (bus.slave)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] m_q [$];
    logic [1:0] m_ovf;

    typedef struct {
        logic       swr;
        logic [7:0] swd;
        logic       rrd;
        logic       clr;
        logic       exp_v;
        logic [7:0] exp_d;
        logic [1:0] exp_o;
    } rsp_vec_t;
    rsp_vec_t vt [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_strobes();
        bus.wr68k_stb  = 1'b0;
        bus.rd68k_stb  = 1'b0;
        bus.snd_rd_stb = 1'b0;
        bus.snd_wr_stb = 1'b0;
        bus.ovf_clr    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_q.delete();
        m_ovf = 2'b00;
    endtask

    task automatic push(input logic [7:0] b);
        bus.wr68k_stb  = 1'b1;
        bus.wr68k_data = b;
        if (m_q.size() < DEPTH) m_q.push_back(b);
        else                    m_ovf[0] = 1'b1;
        step();
        $display("[TB] push 0x%02h pend=%0b full=%0b", b, bus.snd_cmd_pend, bus.cmd_full);
    endtask

    task automatic pop_check();
        logic [7:0] exp;
        exp = m_q.pop_front();
        chk("pop_head", {24'd0, bus.snd_cmd_data}, {24'd0, exp});
        bus.snd_rd_stb = 1'b1;
        step();
        $display("[TB] pop 0x%02h remaining=%0d", exp, m_q.size());
        chk("pend_after_pop", {31'd0, bus.snd_cmd_pend}, {31'd0, m_q.size() != 0});
        if (m_q.size() != 0)
            chk("head_after_pop", {24'd0, bus.snd_cmd_data}, {24'd0, m_q[0]});
    endtask

    // Counts sampled cycles while sndnmi stays at lvl; bounded so a stuck DUT still ends.
    task automatic count_while(input logic lvl, output int n);
        n = 0;
        while (bus.sndnmi === lvl && n < 100) begin
            n++;
            step();
        end
        if (n >= 100) begin
            tests++;
            fails++;
            $display("FAIL nmi_timeout: sndnmi stuck at %0b for %0d cycles, required change", lvl, n);
        end
    endtask

    task automatic check_no_pulse(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (bus.sndnmi) seen = 1'b1;
        end
        chk(name, {31'd0, seen}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        chk({tag, "_rd68k_data"}, {24'd0, bus.rd68k_data}, 32'd0);
        chk({tag, "_cmd_full"}, {31'd0, bus.cmd_full}, 32'd0);
        chk({tag, "_ovf"}, {30'd0, bus.ovf_flags}, 32'd0);
        chk({tag, "_cmd_data"}, {24'd0, bus.snd_cmd_data}, 32'd0);
        chk({tag, "_pend"}, {31'd0, bus.snd_cmd_pend}, 32'd0);
        chk({tag, "_sndnmi"}, {31'd0, bus.sndnmi}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n;
        logic [7:0] prev_d;
        logic [7:0] b;

        vt[0] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 2'b00};
        vt[1] = '{1'b1, 8'h3D, 1'b0, 1'b0, 1'b1, 8'h3D, 2'b10};
        vt[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h3D, 2'b00};
        vt[3] = '{1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 8'h40, 2'b00};
        vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h40, 2'b00};
        vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h40, 2'b00};
        vt[6] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 2'b00};
        vt[7] = '{1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 8'h42, 2'b10};
        vt[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h42, 2'b00};
        vt[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h42, 2'b00};

        clear_strobes();
        bus.wr68k_data  = 8'h00;
        bus.snd_wr_data = 8'h00;

        // T1: reset state, single command, one 8-cycle pulse, no repeat after pop
        do_reset();
        check_all_zero("reset");
        push(8'h12);
        chk("t1_pend", {31'd0, bus.snd_cmd_pend}, 32'd1);
        chk("t1_data", {24'd0, bus.snd_cmd_data}, 32'h12);
        count_while(1'b0, n);
        count_while(1'b1, n);
        chk("t1_pulse_width", n, W);
        pop_check();
        check_no_pulse("t1_no_second_pulse", 20);

        // T2: overflow on fifth push, then four pop/NMI rounds
        do_reset();
        for (int i = 0; i < 5; i++) begin
            b = 8'hA1 + 8'(i);
            push(b);
        end
        chk("t2_full", {31'd0, bus.cmd_full}, 32'd1);
        chk("t2_ovf", {30'd0, bus.ovf_flags}, {30'd0, m_ovf});
        count_while(1'b1, n);
        pop_check();
        for (int r = 1; r < 4; r++) begin
            count_while(1'b0, n);
            chk("t2_gap_low", {31'd0, n >= G}, 32'd1);
            count_while(1'b1, n);
            chk("t2_pulse_width", n, W);
            pop_check();
        end
        bus.ovf_clr = 1'b1;
        step();
        m_ovf = 2'b00;
        chk("t2_ovf_clr", {30'd0, bus.ovf_flags}, 32'd0);

        // T3: push + pop on a full FIFO
        do_reset();
        for (int i = 0; i < 4; i++) begin
            b = 8'hB1 + 8'(i);
            push(b);
        end
        chk("t3_full", {31'd0, bus.cmd_full}, 32'd1);
        b = m_q.pop_front();
        chk("t3_head", {24'd0, bus.snd_cmd_data}, {24'd0, b});
        m_q.push_back(8'h55);
        bus.wr68k_stb  = 1'b1;
        bus.wr68k_data = 8'h55;
        bus.snd_rd_stb = 1'b1;
        step();
        $display("[TB] push 0x55 + pop 0x%02h", b);
        chk("t3_still_full", {31'd0, bus.cmd_full}, 32'd1);
        chk("t3_no_ovf", {30'd0, bus.ovf_flags}, 32'd0);
        chk("t3_new_head", {24'd0, bus.snd_cmd_data}, {24'd0, m_q[0]});
        for (int i = 0; i < 4; i++) pop_check();

        // T4: response latch vectors
        do_reset();
        prev_d = 8'h00;
        for (int i = 0; i < 10; i++) begin
            bus.snd_wr_stb  = vt[i].swr;
            bus.snd_wr_data = vt[i].swd;
            bus.rd68k_stb   = vt[i].rrd;
            bus.ovf_clr     = vt[i].clr;
            if (vt[i].rrd)
                chk("t4_read_byte", {24'd0, bus.rd68k_data}, {24'd0, prev_d});
            step();
            $display("[TB] rsp vec %0d: valid=%0b data=0x%02h ovf=%02b", i,
                     bus.rsp_valid, bus.rd68k_data, bus.ovf_flags);
            chk("t4_valid", {31'd0, bus.rsp_valid}, {31'd0, vt[i].exp_v});
            chk("t4_data", {24'd0, bus.rd68k_data}, {24'd0, vt[i].exp_d});
            chk("t4_ovf", {30'd0, bus.ovf_flags}, {30'd0, vt[i].exp_o});
            prev_d = vt[i].exp_d;
        end

        // T5: pop during the pulse does not shorten it; empty pop is harmless
        do_reset();
        push(8'h77);
        count_while(1'b0, n);
        pop_check();
        count_while(1'b1, n);
        chk("t5_pulse_width", n + 1, W);
        check_no_pulse("t5_no_second_pulse", 20);
        bus.snd_rd_stb = 1'b1;
        step();
        $display("[TB] pop on empty FIFO");
        chk("t5_empty_pend", {31'd0, bus.snd_cmd_pend}, 32'd0);
        chk("t5_empty_data", {24'd0, bus.snd_cmd_data}, 32'h77);
        chk("t5_empty_full", {31'd0, bus.cmd_full}, 32'd0);

        // T6: asynchronous reset in the middle of a pulse
        do_reset();
        for (int i = 0; i < 5; i++) begin
            b = 8'hC1 + 8'(i);
            push(b);
        end
        chk("t6_pre_nmi", {31'd0, bus.sndnmi}, 32'd1);
        chk("t6_pre_ovf", {30'd0, bus.ovf_flags}, {30'd0, m_ovf});
        #2;
        rst = 1'b1;
        #1;
        $display("[TB] async reset mid-pulse");
        check_all_zero("t6_async");
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_ovf = 2'b00;
        step();
        chk("t6_after_pend", {31'd0, bus.snd_cmd_pend}, 32'd0);
        chk("t6_after_nmi", {31'd0, bus.sndnmi}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
